// File: rtl/dbf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbf_pkg
// Description : Shared defaults and the commit-FSM state type for the DBF
//               beam-weight loader.
// Revision    : 1.0 - initial release
// ============================================================================
package dbf_pkg;

  localparam int DBF_NCH   = 8;   // channels driven in parallel (power of two)
  localparam int DBF_NBEAM = 4;   // stored beam coefficient sets (power of two)
  localparam int DBF_CW    = 16;  // coefficient width (fix16_13)

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dbf_weight_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : dbf_weight_loader_if
// Description : Host write bus, commit/frame control and coefficient outputs
//               of the DBF weight loader.
//   master : host side   (drives writes, commit, beam_sel, frame_start)
//   slave  : loader side (drives wr_ready, coefficients, valid/done pulses)
// Revision    : 1.0 - initial release
// ============================================================================
interface dbf_weight_loader_if
  import dbf_pkg::*;
#(
  parameter int NCH   = DBF_NCH,
  parameter int NBEAM = DBF_NBEAM,
  parameter int CW    = DBF_CW
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic [$clog2(NBEAM)-1:0] wr_beam;
  logic [$clog2(NCH)-1:0]   wr_ch;
  logic [CW-1:0]            wr_A;
  logic [CW-1:0]            wr_re;
  logic [CW-1:0]            wr_im;
  logic                     commit;
  logic [$clog2(NBEAM)-1:0] beam_sel;
  logic                     frame_start;
  logic [NCH*CW-1:0]        A_out;
  logic [NCH*CW-1:0]        ph_real_out;
  logic [NCH*CW-1:0]        ph_image_out;
  logic                     phase_data_valid;
  logic                     commit_done;

  modport master (
    output wr_valid, wr_beam, wr_ch, wr_A, wr_re, wr_im,
    output commit, beam_sel, frame_start,
    input  wr_ready, A_out, ph_real_out, ph_image_out,
    input  phase_data_valid, commit_done
  );

  modport slave (
    input  wr_valid, wr_beam, wr_ch, wr_A, wr_re, wr_im,
    input  commit, beam_sel, frame_start,
    output wr_ready, A_out, ph_real_out, ph_image_out,
    output phase_data_valid, commit_done
  );

endinterface
`default_nettype wire

// File: rtl/dbf_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : dbf_coef_bank
// Description : NBEAM x NCH register array of {A, re, im} coefficients with
//               one write port and one NCH-wide read port for a whole beam.
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   we_i, wbeam_i, wch_i: write strobe and target entry
//   wa_i, wre_i, wim_i  : write data
//   rbeam_i             : beam to read
//   ra_o, rre_o, rim_o  : beam coefficients, channel k at [k*CW +: CW]
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_coef_bank
  import dbf_pkg::*;
#(
  parameter int NCH   = DBF_NCH,
  parameter int NBEAM = DBF_NBEAM,
  parameter int CW    = DBF_CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic [$clog2(NBEAM)-1:0] wbeam_i,
  input  logic [$clog2(NCH)-1:0]   wch_i,
  input  logic [CW-1:0]            wa_i,
  input  logic [CW-1:0]            wre_i,
  input  logic [CW-1:0]            wim_i,
  input  logic [$clog2(NBEAM)-1:0] rbeam_i,
  output logic [NCH*CW-1:0]        ra_o,
  output logic [NCH*CW-1:0]        rre_o,
  output logic [NCH*CW-1:0]        rim_o
);

  logic [CW-1:0] a_q  [NBEAM][NCH];
  logic [CW-1:0] re_q [NBEAM][NCH];
  logic [CW-1:0] im_q [NBEAM][NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBEAM; b++) begin
        for (int c = 0; c < NCH; c++) begin
          a_q[b][c]  <= '0;
          re_q[b][c] <= '0;
          im_q[b][c] <= '0;
        end
      end
    end else if (we_i) begin
      a_q[wbeam_i][wch_i]  <= wa_i;
      re_q[wbeam_i][wch_i] <= wre_i;
      im_q[wbeam_i][wch_i] <= wim_i;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_rd
    assign ra_o[k*CW +: CW]  = a_q[rbeam_i][k];
    assign rre_o[k*CW +: CW] = re_q[rbeam_i][k];
    assign rim_o[k*CW +: CW] = im_q[rbeam_i][k];
  end

endmodule
`default_nettype wire

// File: rtl/dbf_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : dbf_weight_loader
// Description : Double-buffered beam-weight store for NCH dbf_cell channels.
//               Host writes go to the shadow bank; a commit arms a bank swap
//               that takes effect on the next frame_start, so coefficient
//               outputs only ever change on frame boundaries.
//   clk, rst_n : clock, async active-low reset
//   wl         : host write bus, commit/frame control, coefficient outputs
// Revision    : 1.0 - initial release
// ============================================================================
module dbf_weight_loader
  import dbf_pkg::*;
#(
  parameter int NCH   = DBF_NCH,
  parameter int NBEAM = DBF_NBEAM,
  parameter int CW    = DBF_CW
) (
  input  logic               clk,
  input  logic               rst_n,
  dbf_weight_loader_if.slave wl
);

  localparam int VW = NCH * CW;

  state_t          state_q;
  logic            bank_act_q;
  logic            ready_q;     // low during reset, high from first edge after
  logic            pdv_q;
  logic            cdone_q;
  logic [VW-1:0]   a_q, re_q, im_q;

  logic            accept;
  logic            swap;
  logic            rd_bank;
  logic [VW-1:0]   a0, re0, im0, a1, re1, im1;

  assign wl.wr_ready = ready_q & (state_q == IDLE);
  assign accept      = wl.wr_valid & wl.wr_ready;
  assign swap        = (state_q == PENDING) & wl.frame_start;
  // A frame that performs the swap must already present the new bank.
  assign rd_bank     = bank_act_q ^ swap;

  // The shadow bank is always the one not selected by bank_act_q.
  dbf_coef_bank #(.NCH(NCH), .NBEAM(NBEAM), .CW(CW)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept & bank_act_q),
    .wbeam_i (wl.wr_beam),
    .wch_i   (wl.wr_ch),
    .wa_i    (wl.wr_A),
    .wre_i   (wl.wr_re),
    .wim_i   (wl.wr_im),
    .rbeam_i (wl.beam_sel),
    .ra_o    (a0),
    .rre_o   (re0),
    .rim_o   (im0)
  );

  dbf_coef_bank #(.NCH(NCH), .NBEAM(NBEAM), .CW(CW)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (accept & ~bank_act_q),
    .wbeam_i (wl.wr_beam),
    .wch_i   (wl.wr_ch),
    .wa_i    (wl.wr_A),
    .wre_i   (wl.wr_re),
    .wim_i   (wl.wr_im),
    .rbeam_i (wl.beam_sel),
    .ra_o    (a1),
    .rre_o   (re1),
    .rim_o   (im1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bank_act_q <= 1'b0;
      ready_q    <= 1'b0;
      pdv_q      <= 1'b0;
      cdone_q    <= 1'b0;
      a_q        <= '0;
      re_q       <= '0;
      im_q       <= '0;
    end else begin
      ready_q <= 1'b1;
      pdv_q   <= wl.frame_start;
      cdone_q <= swap;
      if (wl.frame_start) begin
        a_q  <= rd_bank ? a1  : a0;
        re_q <= rd_bank ? re1 : re0;
        im_q <= rd_bank ? im1 : im0;
      end
      case (state_q)
        IDLE: begin
          // A commit coinciding with frame_start arms the swap for the
          // following frame; this frame still reads the old bank.
          if (wl.commit) state_q <= PENDING;
        end
        PENDING: begin
          if (wl.frame_start) begin
            bank_act_q <= ~bank_act_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wl.A_out            = a_q;
  assign wl.ph_real_out      = re_q;
  assign wl.ph_image_out     = im_q;
  assign wl.phase_data_valid = pdv_q;
  assign wl.commit_done      = cdone_q;

endmodule
`default_nettype wire

// File: tb/tb_dbf_weight_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbf_weight_loader
// Description : Self-checking bench for dbf_weight_loader. A bank-level
//               model predicts outputs every cycle; literal expectations pin
//               the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbf_weight_loader;
  import dbf_pkg::*;

  localparam int NCH   = DBF_NCH;
  localparam int NBEAM = DBF_NBEAM;
  localparam int CW    = DBF_CW;
  localparam int VW    = NCH * CW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbf_weight_loader_if #(.NCH(NCH), .NBEAM(NBEAM), .CW(CW)) wl();

  dbf_weight_loader #(.NCH(NCH), .NBEAM(NBEAM), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wl    (wl)
  );

  // ---------------- model ----------------
  logic [CW-1:0] mA  [2][NBEAM][NCH];
  logic [CW-1:0] mRe [2][NBEAM][NCH];
  logic [CW-1:0] mIm [2][NBEAM][NCH];
  int   m_act  = 0;
  bit   m_pend = 1'b0;
  bit   m_live = 1'b0;
  logic [CW-1:0] eA [NCH];
  logic [CW-1:0] eRe[NCH];
  logic [CW-1:0] eIm[NCH];
  bit   e_pdv = 1'b0;
  bit   e_cd  = 1'b0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < NBEAM; b++)
        for (int c = 0; c < NCH; c++) begin
          mA[s][b][c] = '0; mRe[s][b][c] = '0; mIm[s][b][c] = '0;
        end
    for (int c = 0; c < NCH; c++) begin
      eA[c] = '0; eRe[c] = '0; eIm[c] = '0;
    end
    m_act = 0; m_pend = 1'b0; m_live = 1'b0; e_pdv = 1'b0; e_cd = 1'b0;
  endtask

  task automatic model_step();
    bit sw;
    int sh;
    sw    = m_pend && wl.frame_start;
    e_pdv = wl.frame_start;
    e_cd  = sw;
    sh    = 1 - m_act;
    if (wl.wr_valid && m_live && !m_pend) begin
      mA[sh][wl.wr_beam][wl.wr_ch]  = wl.wr_A;
      mRe[sh][wl.wr_beam][wl.wr_ch] = wl.wr_re;
      mIm[sh][wl.wr_beam][wl.wr_ch] = wl.wr_im;
    end
    if (sw) begin
      m_act  = 1 - m_act;
      m_pend = 1'b0;
    end else if (!m_pend && wl.commit) begin
      m_pend = 1'b1;
    end
    if (wl.frame_start)
      for (int c = 0; c < NCH; c++) begin
        eA[c]  = mA[m_act][wl.beam_sel][c];
        eRe[c] = mRe[m_act][wl.beam_sel][c];
        eIm[c] = mIm[m_act][wl.beam_sel][c];
      end
    m_live = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("A_out ch%0d", c),        VW'(wl.A_out[c*CW +: CW]),        VW'(eA[c]));
        chk($sformatf("ph_real_out ch%0d", c),  VW'(wl.ph_real_out[c*CW +: CW]),  VW'(eRe[c]));
        chk($sformatf("ph_image_out ch%0d", c), VW'(wl.ph_image_out[c*CW +: CW]), VW'(eIm[c]));
      end
      chk("phase_data_valid", VW'(wl.phase_data_valid), VW'(e_pdv));
      chk("commit_done",      VW'(wl.commit_done),      VW'(e_cd));
      chk("wr_ready",         VW'(wl.wr_ready),         VW'(m_live && !m_pend));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int b, input int c, input logic [CW-1:0] a,
                    input logic [CW-1:0] re, input logic [CW-1:0] im);
    wl.wr_valid = 1'b1;
    wl.wr_beam  = b[$clog2(NBEAM)-1:0];
    wl.wr_ch    = c[$clog2(NCH)-1:0];
    wl.wr_A = a; wl.wr_re = re; wl.wr_im = im;
    tick();
    wl.wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    wl.commit = 1'b1;
    tick();
    wl.commit = 1'b0;
  endtask

  task automatic pulse_fs(input int b);
    wl.beam_sel    = b[$clog2(NBEAM)-1:0];
    wl.frame_start = 1'b1;
    tick();
    wl.frame_start = 1'b0;
  endtask

  initial begin
    wl.wr_valid = 1'b0; wl.wr_beam = '0; wl.wr_ch = '0;
    wl.wr_A = '0; wl.wr_re = '0; wl.wr_im = '0;
    wl.commit = 1'b0; wl.beam_sel = '0; wl.frame_start = 1'b0;

    // Reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset wr_ready", VW'(wl.wr_ready), '0);
    chk("reset A_out",    wl.A_out,         '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("ready after reset", VW'(wl.wr_ready), VW'(1));

    // First frame after reset: all zero, valid, no commit_done
    pulse_fs(0);
    @(negedge clk);
    chk("frame0 A_out",   wl.A_out,       '0);
    chk("frame0 re_out",  wl.ph_real_out, '0);
    chk("frame0 pdv",     VW'(wl.phase_data_valid), VW'(1));
    chk("frame0 cdone",   VW'(wl.commit_done),      '0);

    // Write beam1 ch3, commit, swap
    wr(1, 3, 16'h4000, 16'h2000, 16'hE000);
    pulse_commit();
    pulse_fs(1);
    @(negedge clk);
    chk("b1c3 A",     VW'(wl.A_out[3*CW +: CW]),        VW'(16'h4000));
    chk("b1c3 re",    VW'(wl.ph_real_out[3*CW +: CW]),  VW'(16'h2000));
    chk("b1c3 im",    VW'(wl.ph_image_out[3*CW +: CW]), VW'(16'hE000));
    chk("b1c2 A",     VW'(wl.A_out[2*CW +: CW]),        '0);
    chk("swap cdone", VW'(wl.commit_done),              VW'(1));

    // Write held during PENDING is stalled until IDLE
    pulse_commit();
    wl.wr_valid = 1'b1; wl.wr_beam = 2; wl.wr_ch = 5;
    wl.wr_A = 16'h1111; wl.wr_re = 16'h2222; wl.wr_im = 16'h3333;
    @(negedge clk);
    chk("pending wr_ready", VW'(wl.wr_ready), '0);
    tick();
    wl.beam_sel = 2; wl.frame_start = 1'b1;
    tick();
    wl.frame_start = 1'b0;
    @(negedge clk);
    chk("ready after swap", VW'(wl.wr_ready),        VW'(1));
    chk("stalled b2c5 A",   VW'(wl.A_out[5*CW +: CW]), '0);
    tick();
    wl.wr_valid = 1'b0;

    // commit together with frame_start: old bank now, new bank next frame
    wl.commit = 1'b1; wl.frame_start = 1'b1; wl.beam_sel = 2;
    tick();
    wl.commit = 1'b0; wl.frame_start = 1'b0;
    @(negedge clk);
    chk("same-cycle old A", VW'(wl.A_out[5*CW +: CW]), '0);
    chk("same-cycle cdone", VW'(wl.commit_done),       '0);
    pulse_fs(2);
    @(negedge clk);
    chk("next frame A",  VW'(wl.A_out[5*CW +: CW]),        VW'(16'h1111));
    chk("next frame re", VW'(wl.ph_real_out[5*CW +: CW]),  VW'(16'h2222));
    chk("next frame im", VW'(wl.ph_image_out[5*CW +: CW]), VW'(16'h3333));
    chk("next frame cd", VW'(wl.commit_done),              VW'(1));

    // beam_sel change without frame_start has no effect
    pulse_fs(0);
    wl.beam_sel = 2;
    tick();
    tick();
    @(negedge clk);
    chk("beam_sel hold A",   wl.A_out,                   '0);
    chk("beam_sel hold pdv", VW'(wl.phase_data_valid),   '0);

    // Back-to-back frame_start
    wl.beam_sel = 2; wl.frame_start = 1'b1;
    tick();
    wl.beam_sel = 1;
    @(negedge clk);
    chk("b2b first pdv", VW'(wl.phase_data_valid),   VW'(1));
    chk("b2b first A",   VW'(wl.A_out[5*CW +: CW]),  VW'(16'h1111));
    tick();
    wl.frame_start = 1'b0;
    @(negedge clk);
    chk("b2b second pdv", VW'(wl.phase_data_valid),  VW'(1));
    chk("b2b second A",   VW'(wl.A_out[5*CW +: CW]), '0);

    // Reset while PENDING discards the commit
    wr(0, 0, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    pulse_commit();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid-reset A",     wl.A_out,         '0);
    chk("mid-reset ready", VW'(wl.wr_ready), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post-reset ready", VW'(wl.wr_ready), VW'(1));
    pulse_fs(0);
    @(negedge clk);
    chk("post-reset A ch0", VW'(wl.A_out[0 +: CW]), '0);
    chk("post-reset cdone", VW'(wl.commit_done),    '0);
    pulse_fs(0);
    @(negedge clk);
    chk("discarded cdone",  VW'(wl.commit_done),    '0);
    chk("discarded A ch0",  VW'(wl.A_out[0 +: CW]), '0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbf_weight_loader.md
DBF_WEIGHT_LOADER -- requirements
Module: dbf_weight_loader

Interface
REQ-001 Parameter NCH, default 8: number of dbf_cell channels driven in parallel; power of two.
REQ-002 Parameter NBEAM, default 4: number of stored beam coefficient sets; power of two.
REQ-003 Parameter CW, default 16: coefficient width.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_valid  in  1  host coefficient write request.
REQ-008 wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-009 wr_beam  in  log2(NBEAM)  target beam index.
REQ-010 wr_ch  in  log2(NCH)  target channel index.
REQ-011 wr_A / wr_re / wr_im  in  CW each  gain, phase real, phase imaginary (fix16_13).
REQ-012 commit  in  1  single-cycle request to swap the shadow bank to active.
REQ-013 beam_sel  in  log2(NBEAM)  beam to present, sampled on frame_start.
REQ-014 frame_start  in  1  single-cycle frame boundary strobe.
REQ-015 A_out / ph_real_out / ph_image_out  out  NCH*CW each  per-channel coefficients, channel k at bits [k*CW +: CW].
REQ-016 phase_data_valid  out  1  one-cycle pulse when coefficient outputs update.
REQ-017 commit_done  out  1  one-cycle pulse coincident with phase_data_valid when a swap took effect.

Function
REQ-018 Two banks of NBEAM x NCH entries {A, re, im}, each CW bits; bank_act selects the active bank, the other is the shadow bank.
REQ-019 An accepted write updates only shadow[wr_beam][wr_ch]; active bank and outputs are unaffected.
REQ-020 FSM states: IDLE, PENDING.
REQ-021 IDLE: wr_ready=1; commit=1 -> PENDING.
REQ-022 PENDING: wr_ready=0; commit ignored; frame_start=1 -> toggle bank_act, set commit_done, -> IDLE.
REQ-023 A write and commit in the same IDLE cycle: write lands in the current shadow, then -> PENDING.
REQ-024 commit and frame_start in the same IDLE cycle: this frame loads from the old active bank; swap occurs on the next frame_start.
REQ-025 On every frame_start (cycle n), at cycle n+1 the outputs hold the active bank entries for beam_sel as sampled at n (post-swap bank if a swap occurred at n), and phase_data_valid=1 for exactly cycle n+1.
REQ-026 Outputs hold their values between frame_start strobes; beam_sel changes without frame_start have no effect.
REQ-027 Back-to-back frame_start (n, n+1): outputs reload each cycle; phase_data_valid high for n+1 and n+2.
REQ-028 No arithmetic; coefficients pass bit-exact.

Reset
REQ-029 During rst_n=0: state=IDLE, bank_act=0, all entries of both banks 0, all outputs 0, phase_data_valid=0, commit_done=0, wr_ready=0.
REQ-030 wr_ready=1 from the first clock edge after rst_n deasserts; reset mid-PENDING discards the pending commit.

Structure
REQ-031 Package dbf_pkg holds NCH, NBEAM, CW defaults and the FSM state enum {IDLE, PENDING}.
REQ-032 One sub-module dbf_coef_bank: register array with one write port and one NCH-wide beam read port; instantiated twice.
REQ-033 Outputs registered; no combinational path from inputs to outputs except wr_ready from state.

Verification
REQ-034 Reset then frame_start, beam_sel=0 -> next cycle all outputs 0, phase_data_valid=1, commit_done=0.
REQ-035 Write beam1 ch3 {0x4000,0x2000,0xE000}, commit, frame_start with beam_sel=1 -> next cycle ch3 slices = those values, other channels 0, commit_done=1.
REQ-036 Write during PENDING (wr_valid=1) -> wr_ready=0, no shadow change until next IDLE; write then accepted.
REQ-037 commit and frame_start in same cycle -> first frame shows old bank, commit_done=0; next frame_start shows new bank, commit_done=1.
REQ-038 rst_n low while PENDING -> after release state IDLE, bank_act=0, outputs 0.
REQ-039 beam_sel toggles 0->2 with no frame_start -> outputs unchanged, phase_data_valid stays 0.
